retire_stage: RTL and testbench
===============================

RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 Parameter N, default `N: superscalar retire width.
REQ-002 Parameter PR_BITS, default $clog2(`PHYS_REG_SZ): physical register tag width.
REQ-003 Parameter NUM_SCALAR_BITS, derived $clog2(N+1): width of all counts.
REQ-004 clock  input  1  clock; reset is synchronous, active-high; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 rob_outputs  input  N x ROB_EXIT_PACKET  ROB head entries, index 0 oldest; used fields complete, mispredict, halt, has_dest, t, t_old.
REQ-007 outputs_valid  input  NUM_SCALAR_BITS  count of valid head entries (0..N).
REQ-008 num_retiring  output  NUM_SCALAR_BITS  entries the ROB pops this cycle.
REQ-009 free_valid  output  N  per-slot: free t_old of retiring entry i.
REQ-010 free_reg  output  N x PR_BITS  t_old of slot i.
REQ-011 arch_wr_en  output  N  per-slot architectural map write enable.
REQ-012 arch_wr_t  output  N x PR_BITS  t of slot i.
REQ-013 flush  output  1  pipeline flush pulse (mispredict retired).
REQ-014 halted  output  1  sticky: halt instruction retired.
REQ-015 retired_count  output  32  total instructions retired since reset.

Function
REQ-016 FSM states RUN, FLUSH, HALTED; reset state RUN.
REQ-017 In RUN, slot i retires iff i < outputs_valid, rob_outputs[i].complete, all slots j<i retire, and no slot j<i has mispredict or halt set.
REQ-018 num_retiring = count of retiring slots, combinational, same cycle; always <= outputs_valid.
REQ-019 Retiring slots form a contiguous prefix from slot 0; nothing at or after the first incomplete slot retires.
REQ-020 free_valid[i] = retiring[i] & has_dest; arch_wr_en[i] = retiring[i] & has_dest; non-retiring slots drive 0.
REQ-021 A retiring slot with mispredict set: that slot retires, later slots do not, flush=1 combinationally that cycle, next state FLUSH.
REQ-022 FLUSH lasts exactly one cycle: num_retiring=0, all enables 0, flush=0; next state RUN.
REQ-023 A retiring slot with halt set: it retires, later slots do not, next state HALTED; halted=1 from the following cycle.
REQ-024 HALTED: num_retiring=0, enables 0, flush=0, halted=1; exits only via reset.
REQ-025 A slot with both mispredict and halt set is treated as halt; flush=0.
REQ-026 retired_count += num_retiring each cycle; wraps modulo 2^32.
REQ-027 outputs_valid=0, or slot 0 incomplete: num_retiring=0, no side effects.

Reset
REQ-028 Reset takes priority over all other inputs; during the reset cycle num_retiring=0, all enables 0, flush=0.
REQ-029 After reset: state RUN, halted=0, retired_count=0, from any state including FLUSH and HALTED.

Verification
REQ-030 N=3, outputs_valid=3, all complete, no flags -> num_retiring=3, retired_count +3 next cycle.
REQ-031 outputs_valid=3, complete={1,0,1} -> num_retiring=1; only slot 0 frees t_old.
REQ-032 outputs_valid=3, all complete, slot1 mispredict -> num_retiring=2, flush=1; next cycle num_retiring=0; cycle after, retirement resumes.
REQ-033 Slot0 halt, complete -> num_retiring=1; next cycle halted=1 and num_retiring=0 for 10+ cycles despite complete entries.
REQ-034 has_dest=0 on a retiring slot -> free_valid/arch_wr_en for that slot = 0 while num_retiring still counts it.
REQ-035 Reset asserted while HALTED with retired_count=7 -> next cycle halted=0, retired_count=0, RUN.

Source files
------------

// File: rtl/retire_stage_if.sv
// Retire-stage package (ROB exit packet) and ROB/retire interface.
// Ports: rob_outputs/outputs_valid in; retire counts, free/arch writes, flush, halted out.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package retire_pkg;
  localparam int PR_W = $clog2(`PHYS_REG_SZ);

  typedef struct packed {
    logic            complete;
    logic            mispredict;
    logic            halt;
    logic            has_dest;
    logic [PR_W-1:0] t;
    logic [PR_W-1:0] t_old;
  } rob_exit_packet_t;
endpackage

interface retire_stage_if
  import retire_pkg::*;
#(
  parameter int N       = `N,
  parameter int PR_BITS = PR_W,
  parameter int NSB     = $clog2(N+1)
);
  rob_exit_packet_t [N-1:0]   rob_outputs;
  logic [NSB-1:0]             outputs_valid;
  logic [NSB-1:0]             num_retiring;
  logic [N-1:0]               free_valid;
  logic [N-1:0][PR_BITS-1:0]  free_reg;
  logic [N-1:0]               arch_wr_en;
  logic [N-1:0][PR_BITS-1:0]  arch_wr_t;
  logic                       flush;
  logic                       halted;
  logic [31:0]                retired_count;

  modport master (
    output rob_outputs, outputs_valid,
    input  num_retiring, free_valid, free_reg,
    input  arch_wr_en, arch_wr_t, flush,
    input  halted, retired_count
  );

  modport slave (
    input  rob_outputs, outputs_valid,
    output num_retiring, free_valid, free_reg,
    output arch_wr_en, arch_wr_t, flush,
    output halted, retired_count
  );
endinterface

// File: rtl/retire_stage.sv
// In-order superscalar retire: pops a contiguous complete prefix of the ROB head.
// Ports: clock, reset (sync, active-high), bus (retire_stage_if.slave).
module retire_stage
  import retire_pkg::*;
#(
  parameter  int N               = `N,
  parameter  int PR_BITS         = PR_W,
  localparam int NUM_SCALAR_BITS = $clog2(N+1)
) (
  input logic           clock,
  input logic           reset,
  retire_stage_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                     state;
  state_t                     next_state;
  logic [31:0]                count_q;
  logic [N-1:0]               retiring;
  logic [NUM_SCALAR_BITS-1:0] n_ret;
  logic                       flush_c;
  logic                       stop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RUN;
      count_q <= '0;
    end else begin
      state   <= next_state;
      count_q <= count_q + 32'(n_ret);
    end
  end

  // Walk slots oldest-first; the first incomplete slot or the
  // first halt/mispredict (inclusive) ends the retiring prefix.
  always_comb begin
    next_state = state;
    retiring   = '0;
    n_ret      = '0;
    flush_c    = 1'b0;
    stop       = 1'b0;
    unique case (state)
      RUN: begin
        if (!reset) begin
          for (int i = 0; i < N; i++) begin
            if (!stop) begin
              if (NUM_SCALAR_BITS'(i) < bus.outputs_valid &&
                  bus.rob_outputs[i].complete) begin
                retiring[i] = 1'b1;
                n_ret       = n_ret + NUM_SCALAR_BITS'(1);
                // halt wins over mispredict
                if (bus.rob_outputs[i].halt) begin
                  stop       = 1'b1;
                  next_state = HALTED;
                end else if (bus.rob_outputs[i].mispredict) begin
                  stop       = 1'b1;
                  flush_c    = 1'b1;
                  next_state = FLUSH;
                end
              end else begin
                stop = 1'b1;
              end
            end
          end
        end
      end
      FLUSH:   next_state = RUN;
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.free_valid[i] = retiring[i] & bus.rob_outputs[i].has_dest;
      bus.arch_wr_en[i] = retiring[i] & bus.rob_outputs[i].has_dest;
      bus.free_reg[i]   = bus.rob_outputs[i].t_old;
      bus.arch_wr_t[i]  = bus.rob_outputs[i].t;
    end
  end

  assign bus.num_retiring  = n_ret;
  assign bus.flush         = flush_c;
  assign bus.halted        = (state == HALTED);
  assign bus.retired_count = count_q;

endmodule

// File: tb/tb_retire_stage.sv
// Self-checking bench for retire_stage (N=3): directed vectors,
// per-cycle reference model plus literal expectations.
module tb_retire_stage;
  import retire_pkg::*;

  typedef rob_exit_packet_t [2:0] vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  retire_stage_if #(.N(3)) bus ();

  retire_stage #(.N(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] c, input logic [2:0] m,
                              input logic [2:0] h, input logic [2:0] d);
    vec_t v;
    for (int i = 0; i < 3; i++) begin
      v[i].complete   = c[i];
      v[i].mispredict = m[i];
      v[i].halt       = h[i];
      v[i].has_dest   = d[i];
      v[i].t          = 6'(i + 1);
      v[i].t_old      = 6'(i + 9);
    end
    return v;
  endfunction

  // Reference model: state held as plain flags and a counter.
  bit          m_halted = 0;
  bit          m_flushing = 0;
  logic [31:0] m_count = '0;
  int          k;
  bit          e_flush;
  bit          e_halt;
  logic [2:0]  e_en;

  always @(negedge clock) begin
    k = 0;
    e_flush = 0;
    e_halt = 0;
    e_en = '0;
    if (!reset && !m_halted && !m_flushing) begin
      while (k < int'(bus.outputs_valid) && k < 3 &&
             bus.rob_outputs[k].complete)
        k++;
      for (int j = 0; j < k; j++) begin
        if (bus.rob_outputs[j].halt || bus.rob_outputs[j].mispredict) begin
          e_halt  = bus.rob_outputs[j].halt;
          e_flush = !bus.rob_outputs[j].halt;
          k = j + 1;
          break;
        end
      end
      for (int j = 0; j < k; j++)
        e_en[j] = bus.rob_outputs[j].has_dest;
    end
    chk("model num_retiring", 64'(bus.num_retiring), 64'(k));
    chk("model flush", 64'(bus.flush), 64'(e_flush));
    chk("model free_valid", 64'(bus.free_valid), 64'(e_en));
    chk("model arch_wr_en", 64'(bus.arch_wr_en), 64'(e_en));
    chk("model halted", 64'(bus.halted), 64'(m_halted));
    chk("model retired_count", 64'(bus.retired_count), 64'(m_count));
    for (int j = 0; j < 3; j++) begin
      if (e_en[j]) begin
        chk("model free_reg", 64'(bus.free_reg[j]), 64'(j + 9));
        chk("model arch_wr_t", 64'(bus.arch_wr_t[j]), 64'(j + 1));
      end
    end
    if (reset) begin
      m_halted   = 0;
      m_flushing = 0;
      m_count    = '0;
    end else if (m_halted || m_flushing) begin
      m_flushing = 0;
    end else begin
      m_count    = m_count + 32'(k);
      m_halted   = e_halt;
      m_flushing = e_flush;
    end
  end

  task automatic cyc(input vec_t v, input int valid, input bit rst);
    @(posedge clock);
    #1;
    bus.rob_outputs   = v;
    bus.outputs_valid = 2'(valid);
    reset             = rst;
    @(negedge clock);
    #1;
  endtask

  vec_t all_c;
  vec_t none;

  initial begin
    all_c = mk(3'b111, 3'b000, 3'b000, 3'b111);
    none  = mk(3'b000, 3'b000, 3'b000, 3'b111);
    bus.rob_outputs   = none;
    bus.outputs_valid = '0;

    cyc(all_c, 3, 1);
    chk("reset cycle nr", 64'(bus.num_retiring), 0);
    chk("reset cycle flush", 64'(bus.flush), 0);
    cyc(none, 0, 0);
    chk("after reset nr", 64'(bus.num_retiring), 0);
    chk("after reset count", 64'(bus.retired_count), 0);
    chk("after reset halted", 64'(bus.halted), 0);

    cyc(all_c, 3, 0);
    chk("all3 nr", 64'(bus.num_retiring), 3);
    chk("all3 free_valid", 64'(bus.free_valid), 7);
    cyc(mk(3'b101, 3'b000, 3'b000, 3'b111), 3, 0);
    chk("all3 count", 64'(bus.retired_count), 3);
    chk("gap nr", 64'(bus.num_retiring), 1);
    chk("gap free_valid", 64'(bus.free_valid), 1);
    cyc(mk(3'b011, 3'b000, 3'b000, 3'b101), 2, 0);
    chk("gap count", 64'(bus.retired_count), 4);
    chk("nodest nr", 64'(bus.num_retiring), 2);
    chk("nodest free_valid", 64'(bus.free_valid), 1);
    chk("nodest arch_wr_en", 64'(bus.arch_wr_en), 1);

    cyc(mk(3'b111, 3'b010, 3'b000, 3'b111), 3, 0);
    chk("mispred count", 64'(bus.retired_count), 6);
    chk("mispred nr", 64'(bus.num_retiring), 2);
    chk("mispred flush", 64'(bus.flush), 1);
    cyc(mk(3'b111, 3'b010, 3'b000, 3'b111), 3, 0);
    chk("flush cycle nr", 64'(bus.num_retiring), 0);
    chk("flush cycle flush", 64'(bus.flush), 0);
    cyc(all_c, 3, 0);
    chk("resume nr", 64'(bus.num_retiring), 3);
    cyc(none, 0, 0);
    chk("resume count", 64'(bus.retired_count), 11);
    chk("empty nr", 64'(bus.num_retiring), 0);
    cyc(mk(3'b110, 3'b000, 3'b000, 3'b111), 3, 0);
    chk("head incomplete nr", 64'(bus.num_retiring), 0);
    chk("head incomplete en", 64'(bus.free_valid), 0);

    cyc(mk(3'b111, 3'b000, 3'b010, 3'b111), 3, 0);
    chk("halt slot1 nr", 64'(bus.num_retiring), 2);
    cyc(all_c, 3, 0);
    chk("halt slot1 halted", 64'(bus.halted), 1);
    chk("halt slot1 count", 64'(bus.retired_count), 13);

    cyc(all_c, 3, 1);
    chk("reset from halt nr", 64'(bus.num_retiring), 0);
    cyc(all_c, 3, 0);
    chk("post reset halted", 64'(bus.halted), 0);
    chk("post reset count", 64'(bus.retired_count), 0);
    chk("post reset nr", 64'(bus.num_retiring), 3);
    cyc(all_c, 3, 0);
    cyc(mk(3'b111, 3'b001, 3'b001, 3'b111), 3, 0);
    chk("halt+mis nr", 64'(bus.num_retiring), 1);
    chk("halt+mis flush", 64'(bus.flush), 0);
    for (int i = 0; i < 12; i++) begin
      cyc(all_c, 3, 0);
      chk("halted sticky", 64'(bus.halted), 1);
      chk("halted nr", 64'(bus.num_retiring), 0);
    end
    chk("halted count", 64'(bus.retired_count), 7);

    cyc(all_c, 3, 1);
    cyc(all_c, 3, 0);
    chk("halt7 reset halted", 64'(bus.halted), 0);
    chk("halt7 reset count", 64'(bus.retired_count), 0);
    chk("halt7 reset nr", 64'(bus.num_retiring), 3);

    cyc(mk(3'b111, 3'b001, 3'b000, 3'b111), 3, 0);
    chk("mis slot0 nr", 64'(bus.num_retiring), 1);
    chk("mis slot0 flush", 64'(bus.flush), 1);
    cyc(all_c, 3, 1);
    cyc(all_c, 3, 0);
    chk("reset from flush count", 64'(bus.retired_count), 0);
    chk("reset from flush nr", 64'(bus.num_retiring), 3);
    cyc(none, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
